// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// A grant is issued in the same cycle as the request. Each grant pushes
// {valid, requester} into a MEM_LATENCY-deep pipeline, so every response beat
// returns to the requester that issued it.
// Optional feature: define SRAM_ARB_LOCK_EN to add lock_i. A locking winner
// keeps ownership for up to LOCK_MAX_BEATS consecutive grants.
module sram_port_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned LOCK_MAX_BEATS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_i,
  input  logic [NUM_REQ-1:0]                we_i,
`ifdef SRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                lock_i,
`endif
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                gnt_o,
  output logic [NUM_REQ-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sram_port_arbiter: NUM_REQ must be 2..8");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("sram_port_arbiter: MEM_LATENCY must be 1..4");
  end
  if (LOCK_MAX_BEATS < 1) begin : g_bad_lock_beats
    $error("sram_port_arbiter: LOCK_MAX_BEATS must be >= 1");
  end

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IdxW-1:0]    winner;
  logic               grant_valid;
  logic               lock_release;
  logic [IdxW-1:0]    owner_idx;

  logic [MEM_LATENCY-1:0] pipe_valid_q;
  logic [IdxW-1:0]        pipe_idx_q [MEM_LATENCY];

`ifdef SRAM_ARB_LOCK_EN
  localparam int unsigned CntW = $clog2(LOCK_MAX_BEATS + 1);

  typedef enum logic {StFree, StOwned} lock_state_e;

  lock_state_e     state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [CntW-1:0] beats_q, beats_d;
  logic            relock_block_q, relock_block_d;

  // Lock state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StFree;
      owner_q        <= '0;
      beats_q        <= '0;
      relock_block_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      beats_q        <= beats_d;
      relock_block_q <= relock_block_d;
    end
  end

  // Lock next state: acquire on a locked grant, release on lock drop or beat limit
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    beats_d        = beats_q;
    relock_block_d = relock_block_q;
    lock_release   = 1'b0;
    case (state_q)
      StFree: begin
        if (grant_valid) begin
          relock_block_d = 1'b0;
          // The previous owner must pass one normal decision before relocking.
          if (lock_i[winner] && !(relock_block_q && winner == owner_q) &&
              LOCK_MAX_BEATS > 1) begin
            state_d = StOwned;
            owner_d = winner;
            beats_d = CntW'(1);
          end
        end
      end
      StOwned: begin
        if (!lock_i[owner_q] || (grant_valid && beats_q == CntW'(LOCK_MAX_BEATS - 1))) begin
          lock_release   = 1'b1;
          state_d        = StFree;
          beats_d        = '0;
          relock_block_d = 1'b1;
        end else if (grant_valid) begin
          beats_d = beats_q + 1'b1;
        end
      end
      default: state_d = StFree;
    endcase
  end

  // Lock outputs: while owned only the owner may compete
  always_comb begin
    eligible  = req_i;
    owner_idx = owner_q;
    if (state_q == StOwned) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (owner_q != IdxW'(i)) eligible[i] = 1'b0;
      end
    end
  end
`else
  assign eligible     = req_i;
  assign lock_release = 1'b0;
  assign owner_idx    = '0;
`endif

  // Round-robin scan starting at the priority pointer
  always_comb begin : scan
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[IdxW'(idx)]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

  assign grant_valid = found & ~rst;

  // Grant decode and SRAM request mux; all zero when idle or in reset
  always_comb begin
    gnt_o       = '0;
    mem_req_o   = grant_valid;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && winner == IdxW'(i)) begin
        gnt_o[i]    = 1'b1;
        mem_we_o    = we_i[i];
        mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_be_o    = be_i[i*BeW +: BeW];
        mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointer next state: winner+1 after a grant, owner+1 on an idle lock release
  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = next_idx(winner);
    end else if (lock_release) begin
      ptr_d = next_idx(owner_idx);
    end
  end

  // Pointer and response pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      pipe_valid_q <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe_idx_q[i] <= '0;
    end else begin
      ptr_q           <= ptr_d;
      pipe_valid_q[0] <= grant_valid;
      pipe_idx_q[0]   <= winner;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_idx_q[i]   <= pipe_idx_q[i-1];
      end
    end
  end

  // Response routing from the pipeline tail; suppressed while in reset
  always_comb begin
    rvalid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!rst && pipe_valid_q[MEM_LATENCY-1] && pipe_idx_q[MEM_LATENCY-1] == IdxW'(i)) begin
        rvalid_o[i] = 1'b1;
      end
    end
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a 2-port/128-bit instance with a small
// SRAM model, and a 4-port/32-bit instance for wrap-around (and lock, when built
// with SRAM_ARB_LOCK_EN). Inputs change just after each negedge; checks run 1ns later.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Instance A: NUM_REQ=2, ADDR=32, DATA=128
  logic [1:0]   a_req, a_we, a_gnt, a_rvalid;
  logic [63:0]  a_addr;
  logic [31:0]  a_be;
  logic [255:0] a_wdata;
  logic [127:0] a_rdata, a_mwdata, a_mrdata;
  logic         a_mreq, a_mwe;
  logic [31:0]  a_maddr;
  logic [15:0]  a_mbe;

  // Instance B: NUM_REQ=4, ADDR=16, DATA=32, LOCK_MAX_BEATS=4
  logic [3:0]   b_req, b_we, b_gnt, b_rvalid;
  logic [63:0]  b_addr;
  logic [15:0]  b_be;
  logic [127:0] b_wdata;
  logic [31:0]  b_rdata, b_mwdata;
  logic         b_mreq, b_mwe;
  logic [15:0]  b_maddr;
  logic [3:0]   b_mbe;
  logic [31:0]  b_mrdata = 32'hDEAD_BEEF;

`ifdef SRAM_ARB_LOCK_EN
  logic [1:0] a_lock = '0;
  logic [3:0] b_lock = '0;
`endif

  sram_port_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(128), .MEM_LATENCY(1), .LOCK_MAX_BEATS(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we),
`ifdef SRAM_ARB_LOCK_EN
    .lock_i(a_lock),
`endif
    .addr_i(a_addr), .be_i(a_be), .wdata_i(a_wdata), .gnt_o(a_gnt), .rvalid_o(a_rvalid),
    .rdata_o(a_rdata), .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_addr_o(a_maddr),
    .mem_be_o(a_mbe), .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mrdata)
  );

  sram_port_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(1), .LOCK_MAX_BEATS(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we),
`ifdef SRAM_ARB_LOCK_EN
    .lock_i(b_lock),
`endif
    .addr_i(b_addr), .be_i(b_be), .wdata_i(b_wdata), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata), .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_addr_o(b_maddr),
    .mem_be_o(b_mbe), .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata)
  );

  // SRAM model for instance A: 1-cycle read latency, byte-enabled writes
  logic [127:0] sram [256];
  always @(posedge clk) begin
    if (a_mreq) begin
      if (a_mwe) begin
        for (int b = 0; b < 16; b++) begin
          if (a_mbe[b]) sram[a_maddr[11:4]][8*b +: 8] <= a_mwdata[8*b +: 8];
        end
      end else begin
        a_mrdata <= sram[a_maddr[11:4]];
      end
    end
  end

  localparam logic [127:0] PatA5 = {16{8'hA5}};
  localparam logic [127:0] Pat5A = {16{8'h5A}};

  task automatic idle_inputs();
    a_req = '0; a_we = '0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_be = '0; b_wdata = '0;
`ifdef SRAM_ARB_LOCK_EN
    a_lock = '0; b_lock = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_req = 2'b11; b_req = 4'b1111;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b00) $display("FAIL reset_gnt_a: got %b want 00", a_gnt); else pass_cnt++;
    chk_cnt++;
    if (a_mreq !== 1'b0) $display("FAIL reset_mreq_a: got %b want 0", a_mreq); else pass_cnt++;
    chk_cnt++;
    if (b_gnt !== 4'b0000) $display("FAIL reset_gnt_b: got %b want 0000", b_gnt); else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b00) $display("FAIL reset_rvalid_a: got %b want 00", a_rvalid);
    else pass_cnt++;
    chk_cnt++;
    if (b_mreq !== 1'b0) $display("FAIL reset_mreq_b: got %b want 0", b_mreq); else pass_cnt++;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b00 || a_mreq !== 1'b0 || a_maddr !== 32'h0)
      $display("FAIL post_reset_idle: got rvalid=%b mreq=%b addr=%h want 00/0/0",
               a_rvalid, a_mreq, a_maddr);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    // Write 0x40
    a_req = 2'b01; a_we = 2'b01; a_addr[31:0] = 32'h40; a_be[15:0] = 16'hFFFF;
    a_wdata[127:0] = PatA5;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b01 || a_mreq !== 1'b1 || a_mwe !== 1'b1)
      $display("FAIL single_wr_gnt: got gnt=%b req=%b we=%b want 01/1/1", a_gnt, a_mreq, a_mwe);
    else pass_cnt++;
    chk_cnt++;
    if (a_maddr !== 32'h40 || a_mbe !== 16'hFFFF || a_mwdata !== PatA5)
      $display("FAIL single_wr_payload: got addr=%h be=%h data=%h", a_maddr, a_mbe, a_mwdata);
    else pass_cnt++;
    // Read 0x40
    @(negedge clk);
    a_we = 2'b00;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b01 || a_mwe !== 1'b0)
      $display("FAIL single_rd_gnt: got gnt=%b we=%b want 01/0", a_gnt, a_mwe);
    else pass_cnt++;
    chk_cnt++;
    if (a_rvalid !== 2'b01) $display("FAIL single_wr_rvalid: got %b want 01", a_rvalid);
    else pass_cnt++;
    @(negedge clk);
    a_req = 2'b00;
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b01 || a_rdata !== PatA5)
      $display("FAIL single_rd_data: got rvalid=%b data=%h want 01/%h", a_rvalid, a_rdata, PatA5);
    else pass_cnt++;
    chk_cnt++;
    if (a_gnt !== 2'b00 || a_mreq !== 1'b0)
      $display("FAIL single_idle: got gnt=%b mreq=%b want 00/0", a_gnt, a_mreq);
    else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b00) $display("FAIL single_rvalid_clear: got %b want 00", a_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [1:0]  prev_gnt;
    logic [31:0] exp_addr;
    do_reset();
    prev_gnt = 2'b00;
    a_req = 2'b11; a_we = 2'b00;
    a_addr = {32'h200, 32'h100};
    for (int k = 0; k < 6; k++) begin
      exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      #1;
      chk_cnt++;
      if (a_gnt !== exp_gnt || a_maddr !== exp_addr)
        $display("FAIL contention_gnt[%0d]: got gnt=%b addr=%h want %b/%h",
                 k, a_gnt, a_maddr, exp_gnt, exp_addr);
      else pass_cnt++;
      chk_cnt++;
      if (a_rvalid !== prev_gnt)
        $display("FAIL contention_rvalid[%0d]: got %b want %b", k, a_rvalid, prev_gnt);
      else pass_cnt++;
      prev_gnt = exp_gnt;
      @(negedge clk);
    end
    a_req = 2'b00;
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b10) $display("FAIL contention_last_rvalid: got %b want 10", a_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    // Grant port 2 to move the pointer to 3
    b_req = 4'b0100;
    #1;
    chk_cnt++;
    if (b_gnt !== 4'b0100) $display("FAIL wrap_setup: got %b want 0100", b_gnt); else pass_cnt++;
    @(negedge clk);
    b_req = 4'b1001;
    #1;
    chk_cnt++;
    if (b_gnt !== 4'b1000 || b_rvalid !== 4'b0100)
      $display("FAIL wrap_first: got gnt=%b rvalid=%b want 1000/0100", b_gnt, b_rvalid);
    else pass_cnt++;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (b_gnt !== 4'b0001 || b_rvalid !== 4'b1000)
      $display("FAIL wrap_second: got gnt=%b rvalid=%b want 0001/1000", b_gnt, b_rvalid);
    else pass_cnt++;
    @(negedge clk);
    b_req = 4'b1111;
    #1;
    chk_cnt++;
    if (b_gnt !== 4'b0010 || b_rvalid !== 4'b0001 || b_rdata !== 32'hDEAD_BEEF)
      $display("FAIL wrap_ptr1: got gnt=%b rvalid=%b rdata=%h want 0010/0001/deadbeef",
               b_gnt, b_rvalid, b_rdata);
    else pass_cnt++;
    @(negedge clk);
    b_req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h40;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b01 || a_rvalid !== 2'b00)
      $display("FAIL b2b_c0: got gnt=%b rvalid=%b want 01/00", a_gnt, a_rvalid);
    else pass_cnt++;
    @(negedge clk);
    a_req = 2'b10; a_we = 2'b10; a_addr[63:32] = 32'h80; a_be[31:16] = 16'hFFFF;
    a_wdata[255:128] = Pat5A;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b10 || a_rvalid !== 2'b01 || a_rdata !== PatA5)
      $display("FAIL b2b_c1: got gnt=%b rvalid=%b rdata=%h want 10/01/%h",
               a_gnt, a_rvalid, a_rdata, PatA5);
    else pass_cnt++;
    chk_cnt++;
    if (a_mwe !== 1'b1 || a_maddr !== 32'h80 || a_mwdata !== Pat5A)
      $display("FAIL b2b_c1_payload: got we=%b addr=%h data=%h", a_mwe, a_maddr, a_mwdata);
    else pass_cnt++;
    @(negedge clk);
    a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h80;
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b10 || a_gnt !== 2'b01)
      $display("FAIL b2b_c2: got rvalid=%b gnt=%b want 10/01", a_rvalid, a_gnt);
    else pass_cnt++;
    @(negedge clk);
    a_req = 2'b00;
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b01 || a_rdata !== Pat5A)
      $display("FAIL b2b_readback: got rvalid=%b rdata=%h want 01/%h", a_rvalid, a_rdata, Pat5A);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    // Advance the pointer to 1 so a return to 0 after reset is visible
    a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h40;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b01) $display("FAIL midflight_grant: got %b want 01", a_gnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; a_req = 2'b11;
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b00 || a_gnt !== 2'b00 || a_mreq !== 1'b0)
      $display("FAIL midflight_in_reset: got rvalid=%b gnt=%b mreq=%b want 00/00/0",
               a_rvalid, a_gnt, a_mreq);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; a_req = 2'b00;
    #1;
    chk_cnt++;
    if (a_rvalid !== 2'b00) $display("FAIL midflight_no_rvalid: got %b want 00", a_rvalid);
    else pass_cnt++;
    @(negedge clk);
    a_req = 2'b11;
    #1;
    chk_cnt++;
    if (a_gnt !== 2'b01) $display("FAIL midflight_ptr0: got %b want 01", a_gnt); else pass_cnt++;
    @(negedge clk);
    a_req = 2'b00;
  endtask

`ifdef SRAM_ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_gnt [9];
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                4'b0001, 4'b0001, 4'b0001, 4'b0010};
    do_reset();
    b_req = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      // Lock held for the first 7 cycles, then dropped
      b_lock = (k < 7) ? 4'b0001 : 4'b0000;
      #1;
      chk_cnt++;
      if (b_gnt !== exp_gnt[k])
        $display("FAIL lock_gnt[%0d]: got %b want %b", k, b_gnt, exp_gnt[k]);
      else pass_cnt++;
      @(negedge clk);
    end
    b_req = 4'b0000; b_lock = 4'b0000;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_back_to_back();
    test_reset_midflight();
`ifdef SRAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port on-chip SRAM (tc_sram, 1-cycle read latency) between NUM_REQ memory-protocol requesters.
- Typical requesters: the axi_to_mem bridge behind the crossbar and the matrix accelerator's direct load/store port.
- Round-robin arbitration with a same-cycle grant.
- Tracks in-flight transactions so that each rvalid/rdata beat is returned to the requester that issued it.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 128, data width in bits; strobe width is DATA_WIDTH/8
MEM_LATENCY, 1, fixed SRAM read latency in cycles (1..4)
LOCK_MAX_BEATS, 16, maximum consecutive grants under lock (used only with SRAM_ARB_LOCK_EN)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
req_i  in  NUM_REQ  per-requester request
we_i  in  NUM_REQ  per-requester write enable
addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester byte address
be_i  in  NUM_REQ*DATA_WIDTH/8  per-requester byte enables
wdata_i  in  NUM_REQ*DATA_WIDTH  per-requester write data
gnt_o  out  NUM_REQ  one-hot grant, combinational from req_i and state
rvalid_o  out  NUM_REQ  one-hot response valid
rdata_o  out  DATA_WIDTH  response data, shared by all requesters, qualified by rvalid_o
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  ADDR_WIDTH  SRAM byte address
mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
mem_wdata_o  out  DATA_WIDTH  SRAM write data
mem_rdata_i  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset state: priority pointer = 0; response pipeline cleared; rvalid_o = 0; lock state idle.
- Reset is synchronous; while rst is high, gnt_o = 0 and mem_req_o = 0.
- Arbitration:
  - Winner is the first requester with req_i=1 scanning from the pointer upward, wrapping at NUM_REQ-1 -> 0.
  - gnt_o[winner]=1 in the same cycle; mem_req_o=1; mem_* driven from the winner's inputs.
  - No request pending: gnt_o = 0, mem_req_o = 0, mem_* = 0.
- Pointer update: after any grant, the pointer becomes (winner+1) mod NUM_REQ. It holds when nothing is granted.
- Handshake:
  - A transaction transfers on req_i & gnt_o.
  - A requester keeps req_i and its payload stable until granted.
  - Losers see gnt_o=0 and retry next cycle.
  - Throughput: one transaction per cycle in aggregate.
- Response tracking:
  - Shift pipeline of depth MEM_LATENCY holds {valid, requester index}; loaded on every grant, reads and writes alike.
  - At the pipeline output: rvalid_o[index]=1 and rdata_o = mem_rdata_i.
  - For writes, rdata_o content is don't-care.
  - Latency is exactly MEM_LATENCY cycles from grant to rvalid.
  - There is no response back-pressure; requesters must accept rvalid in every cycle.
- Simultaneous events: a new grant and a response to a different requester in the same cycle are both legal and independent.
- Reset mid-operation: in-flight responses are discarded (no rvalid after reset); SRAM contents are not touched.
- Address is passed through unmodified; word selection is done at the SRAM instance.

Optional Feature:
SRAM_ARB_LOCK_EN:
- Defined:
  - Adds input port lock_i (NUM_REQ).
  - If the current winner is granted with lock_i=1, ownership is held: next cycle only that requester can be granted, and its requests win regardless of pointer.
  - A beat counter counts consecutive locked grants.
  - Ownership is released when lock_i drops, or when the count reaches LOCK_MAX_BEATS. The release forces one normal round-robin decision before the owner can lock again.
  - While owned and the owner's req_i=0, no grant is issued; other requesters stall.
  - On release, the pointer = owner+1.
- Undefined: no lock_i port; pure round-robin.

Test Plan:
- Single requester: req_i=01, write addr 0x40, be=FFFF, data=A5..A5; then read 0x40 -> gnt_o=01 each cycle; rvalid_o=01 one cycle after the read grant with rdata=A5..A5.
- Contention: req_i=11 held for 6 cycles -> grants alternate 01,10,01,10,01,10; each rvalid arrives MEM_LATENCY cycles after its grant, on the matching bit.
- Wrap-around with NUM_REQ=4: pointer=3, req_i=1001 -> grant 1000 then 0001; pointer ends at 1.
- Back-to-back mixed traffic: cycle 0 read by req0, cycle 1 write by req1 -> rvalid_o=01 at cycle 1 and 10 at cycle 2; the grant in cycle 1 coexists with the rvalid in cycle 1.
- Reset mid-flight: grant a read at cycle 5, assert rst at cycle 5 edge -> no rvalid at cycle 6; pointer=0; gnt_o=0 while rst=1.
- Lock (SRAM_ARB_LOCK_EN, LOCK_MAX_BEATS=4): req0 locks with req_i=11 continuously -> req0 granted 4 cycles, then req1 granted once, then req0 again.
